// File: rtl/acc_b_flags_if.sv
// acc_b_flags_if: bus, load-control and ALU-side signals of the A/B/flags register block.
// ACC_OVF_FLAG_EN adds alu_sub and ovf_flg.
interface acc_b_flags_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
);
    logic [WIDTH-1:0]     bus_in;
    logic [WIDTH-1:0]     bus_out;
    logic                 bus_oe;
    logic                 a_in;
    logic                 a_out;
    logic                 b_in;
    logic                 fl_in;
    logic                 alu_carry;
    logic                 alu_zero;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 carry_flg;
    logic                 zero_flg;
    logic                 ld_done;
    logic                 conflict;
    logic [ERR_CNT_W-1:0] conflict_cnt;
`ifdef ACC_OVF_FLAG_EN
    logic                 alu_sub;
    logic                 ovf_flg;
`endif

    modport master (
`ifdef ACC_OVF_FLAG_EN
        output alu_sub,
        input  ovf_flg,
`endif
        output bus_in, a_in, a_out, b_in, fl_in, alu_carry, alu_zero,
        input  bus_out, bus_oe, a, b, carry_flg, zero_flg, ld_done, conflict, conflict_cnt
    );

    modport slave (
`ifdef ACC_OVF_FLAG_EN
        input  alu_sub,
        output ovf_flg,
`endif
        input  bus_in, a_in, a_out, b_in, fl_in, alu_carry, alu_zero,
        output bus_out, bus_oe, a, b, carry_flg, zero_flg, ld_done, conflict, conflict_cnt
    );
endinterface

// File: rtl/acc_b_flags.sv
// acc_b_flags: accumulator A, operand B and ALU flag register on the shared bus.
// Optional signed-overflow flag enabled by defining ACC_OVF_FLAG_EN.
module acc_b_flags #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
) (
    input logic           clk,
    input logic           clr_n,
    acc_b_flags_if.slave  bif
);
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_ld_done;
    logic                 r_conflict;
    logic [ERR_CNT_W-1:0] r_conflict_cnt;
    logic                 w_conflict;
    logic                 w_cnt_sat;

    assign w_conflict = bif.a_in & bif.a_out;
    assign w_cnt_sat  = &r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_a            <= '0;
            r_b            <= '0;
            r_carry        <= 1'b0;
            r_zero         <= 1'b0;
            r_ld_done      <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            if (bif.a_in) r_a <= bif.bus_in;
            if (bif.b_in) r_b <= bif.bus_in;
            if (bif.fl_in) begin
                r_carry <= bif.alu_carry;
                r_zero  <= bif.alu_zero;
            end
            r_ld_done <= bif.a_in | bif.b_in;
            if (w_conflict) r_conflict <= 1'b1;
            if (w_conflict && !w_cnt_sat) r_conflict_cnt <= r_conflict_cnt + ERR_CNT_W'(1);
        end
    end

    // A load in the same cycle wins over driving A onto the bus
    always_comb begin
        bif.bus_oe  = bif.a_out & ~bif.a_in;
        bif.bus_out = bif.bus_oe ? r_a : '0;
    end

    assign bif.a            = r_a;
    assign bif.b            = r_b;
    assign bif.carry_flg    = r_carry;
    assign bif.zero_flg     = r_zero;
    assign bif.ld_done      = r_ld_done;
    assign bif.conflict     = r_conflict;
    assign bif.conflict_cnt = r_conflict_cnt;

`ifdef ACC_OVF_FLAG_EN
    logic             r_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Overflow is judged from the operands currently held, not from the bus
    always_comb begin
        w_res = bif.alu_sub ? r_a - r_b : r_a + r_b;
        w_ovf = bif.alu_sub ? (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1])
                            : (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!clr_n)         r_ovf <= 1'b0;
        else if (bif.fl_in) r_ovf <= w_ovf;
    end

    assign bif.ovf_flg = r_ovf;
`endif
endmodule

// File: tb/tb_acc_b_flags.sv
// tb_acc_b_flags: directed self-checking bench for acc_b_flags.
module tb_acc_b_flags;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    acc_b_flags_if #(.WIDTH(8), .ERR_CNT_W(4)) bif ();

    acc_b_flags #(.WIDTH(8), .ERR_CNT_W(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bif   (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.bus_in    = '0;
        bif.a_in      = 1'b0;
        bif.a_out     = 1'b0;
        bif.b_in      = 1'b0;
        bif.fl_in     = 1'b0;
        bif.alu_carry = 1'b0;
        bif.alu_zero  = 1'b0;
`ifdef ACC_OVF_FLAG_EN
        bif.alu_sub   = 1'b0;
`endif
    endtask

    task automatic load_a(input logic [7:0] v);
        idle();
        bif.bus_in = v;
        bif.a_in   = 1'b1;
        step();
        idle();
    endtask

    task automatic load_b(input logic [7:0] v);
        idle();
        bif.bus_in = v;
        bif.b_in   = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        clr_n         = 1'b0;
        bif.a_in      = 1'b1;
        bif.bus_in    = 8'hAA;
        bif.fl_in     = 1'b1;
        bif.alu_carry = 1'b1;
        bif.alu_zero  = 1'b1;
        step();
        step();
        clr_n = 1'b1;
        idle();
        total++; if (bif.a !== 8'h00) begin bad++; $display("FAIL reset_a got=%h exp=00", bif.a); end
        total++; if (bif.b !== 8'h00) begin bad++; $display("FAIL reset_b got=%h exp=00", bif.b); end
        total++; if ({bif.carry_flg, bif.zero_flg} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bif.carry_flg, bif.zero_flg}); end
        total++; if (bif.conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", bif.conflict); end
        total++; if (bif.conflict_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bif.conflict_cnt); end
        total++; if (bif.ld_done !== 1'b0) begin bad++; $display("FAIL reset_ld_done got=%b exp=0", bif.ld_done); end
`ifdef ACC_OVF_FLAG_EN
        total++; if (bif.ovf_flg !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bif.ovf_flg); end
`endif
    endtask

    task automatic test_load_drive();
        idle();
        bif.bus_in = 8'hFC;
        bif.a_in   = 1'b1;
        step();
        total++; if (bif.ld_done !== 1'b1) begin bad++; $display("FAIL ld_done_1 got=%b exp=1", bif.ld_done); end
        idle();
        bif.bus_in = 8'h03;
        bif.b_in   = 1'b1;
        step();
        total++; if (bif.ld_done !== 1'b1) begin bad++; $display("FAIL ld_done_2 got=%b exp=1", bif.ld_done); end
        idle();
        total++; if (bif.a !== 8'hFC) begin bad++; $display("FAIL load_a got=%h exp=fc", bif.a); end
        total++; if (bif.b !== 8'h03) begin bad++; $display("FAIL load_b got=%h exp=03", bif.b); end
        total++; if (bif.bus_out !== 8'h00 || bif.bus_oe !== 1'b0) begin bad++; $display("FAIL idle_bus got=%b/%h exp=0/00", bif.bus_oe, bif.bus_out); end
        bif.a_out = 1'b1;
        step();
        total++; if (bif.ld_done !== 1'b0) begin bad++; $display("FAIL ld_done_end got=%b exp=0", bif.ld_done); end
        total++; if (bif.bus_oe !== 1'b1) begin bad++; $display("FAIL drive_oe got=%b exp=1", bif.bus_oe); end
        total++; if (bif.bus_out !== 8'hFC) begin bad++; $display("FAIL drive_out got=%h exp=fc", bif.bus_out); end
        load_a(8'h5A);
        load_b(8'h5A);
        bif.bus_in = 8'h11;
        bif.a_in   = 1'b1;
        bif.b_in   = 1'b1;
        step();
        idle();
        total++; if (bif.a !== 8'h11 || bif.b !== 8'h11) begin bad++; $display("FAIL dual_load got=%h/%h exp=11/11", bif.a, bif.b); end
    endtask

    task automatic test_writeback();
        load_a(8'hFC);
        load_b(8'h04);
        bif.bus_in    = 8'h00;
        bif.alu_carry = 1'b1;
        bif.alu_zero  = 1'b1;
        bif.a_in      = 1'b1;
        bif.fl_in     = 1'b1;
        step();
        idle();
        total++; if (bif.a !== 8'h00) begin bad++; $display("FAIL wb_a got=%h exp=00", bif.a); end
        total++; if ({bif.carry_flg, bif.zero_flg} !== 2'b11) begin bad++; $display("FAIL wb_flags got=%b exp=11", {bif.carry_flg, bif.zero_flg}); end
        step();
        total++; if ({bif.carry_flg, bif.zero_flg} !== 2'b11) begin bad++; $display("FAIL flag_hold got=%b exp=11", {bif.carry_flg, bif.zero_flg}); end
    endtask

    task automatic test_sub_sweep();
        logic [7:0] res;
        logic       cy;
        logic       zr;
        for (int i = 0; i < 12; i++) begin
            load_a(8'h08);
            load_b(8'(i));
            res = 8'h08 - 8'(i);
            cy  = (i <= 8);
            zr  = (i == 8);
            bif.bus_in    = res;
            bif.alu_carry = cy;
            bif.alu_zero  = zr;
            bif.a_in      = 1'b1;
            bif.fl_in     = 1'b1;
            step();
            idle();
            total++; if (bif.a !== res) begin bad++; $display("FAIL sweep_a b=%0d got=%h exp=%h", i, bif.a, res); end
            total++; if ({bif.carry_flg, bif.zero_flg} !== {cy, zr}) begin bad++; $display("FAIL sweep_flags b=%0d got=%b exp=%b", i, {bif.carry_flg, bif.zero_flg}, {cy, zr}); end
        end
    endtask

    task automatic test_conflict();
        logic [7:0] v;
        total++; if (bif.conflict !== 1'b0) begin bad++; $display("FAIL pre_conflict got=%b exp=0", bif.conflict); end
        for (int i = 0; i < 20; i++) begin
            v = 8'h20 + 8'(i);
            bif.bus_in = v;
            bif.a_in   = 1'b1;
            bif.a_out  = 1'b1;
            #1;
            total++; if (bif.bus_oe !== 1'b0 || bif.bus_out !== 8'h00) begin bad++; $display("FAIL conflict_oe i=%0d got=%b/%h exp=0/00", i, bif.bus_oe, bif.bus_out); end
            step();
            total++; if (bif.a !== v) begin bad++; $display("FAIL conflict_a i=%0d got=%h exp=%h", i, bif.a, v); end
            total++; if (bif.conflict !== 1'b1) begin bad++; $display("FAIL conflict_sticky i=%0d got=%b exp=1", i, bif.conflict); end
            total++; if (bif.conflict_cnt !== 4'((i + 1 > 15) ? 15 : i + 1)) begin bad++; $display("FAIL conflict_cnt i=%0d got=%0d exp=%0d", i, bif.conflict_cnt, (i + 1 > 15) ? 15 : i + 1); end
        end
        idle();
        step();
        total++; if (bif.conflict !== 1'b1 || bif.conflict_cnt !== 4'd15) begin bad++; $display("FAIL conflict_hold got=%b/%0d exp=1/15", bif.conflict, bif.conflict_cnt); end
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        total++; if (bif.conflict !== 1'b0 || bif.conflict_cnt !== 4'd0) begin bad++; $display("FAIL conflict_clr got=%b/%0d exp=0/0", bif.conflict, bif.conflict_cnt); end
    endtask

`ifdef ACC_OVF_FLAG_EN
    task automatic test_ovf();
        load_a(8'h7F);
        load_b(8'h01);
        bif.alu_sub = 1'b0;
        bif.fl_in   = 1'b1;
        step();
        idle();
        total++; if (bif.ovf_flg !== 1'b1) begin bad++; $display("FAIL ovf_add got=%b exp=1", bif.ovf_flg); end
        load_a(8'h80);
        bif.alu_sub = 1'b1;
        bif.fl_in   = 1'b1;
        step();
        idle();
        total++; if (bif.ovf_flg !== 1'b1) begin bad++; $display("FAIL ovf_sub got=%b exp=1", bif.ovf_flg); end
        load_a(8'h08);
        load_b(8'h03);
        bif.alu_sub = 1'b1;
        bif.fl_in   = 1'b1;
        step();
        idle();
        total++; if (bif.ovf_flg !== 1'b0) begin bad++; $display("FAIL ovf_none got=%b exp=0", bif.ovf_flg); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_load_drive();
        test_writeback();
        test_sub_sweep();
        test_conflict();
`ifdef ACC_OVF_FLAG_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
